// File: rtl/morse_round_ctrl_pkg.sv
// Shared definitions for the Morse game round sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package morse_round_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/morse_round_ctrl_if.sv
// Signal bundle between game control / timer / ROM and the round sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all requests are single-cycle pulses or levels.
interface morse_round_ctrl_if #(
    parameter int ROUND_W = 4,
    parameter int SCORE_W = 4
);
    import morse_round_ctrl_pkg::*;

    logic                start;
    logic                answer_valid;
    logic                answer_correct;
    logic                tmr_timeout;
    logic                tmr_en;
    logic                tmr_restart;
    logic [ROUND_W-1:0]  round_idx;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  misses;
    logic                playing;
    logic                game_over;
    logic                game_won;
    logic [STATE_W-1:0]  state;

    // Game control / timer side: raises requests, observes round status.
    modport master (
        output start, answer_valid, answer_correct, tmr_timeout,
        input  tmr_en, tmr_restart, round_idx, score, misses,
               playing, game_over, game_won, state
    );

    // Round sequencer side.
    modport slave (
        input  start, answer_valid, answer_correct, tmr_timeout,
        output tmr_en, tmr_restart, round_idx, score, misses,
               playing, game_over, game_won, state
    );
endinterface

// File: rtl/morse_round_ctrl.sv
// Round sequencer: owns the answer timer controls, round index, score and misses.
// Latency: start->tmr_restart 1 cycle, start->tmr_en 2, answer->next tmr_restart 2.
// Backpressure: none; inputs outside their accepting state are dropped.
module morse_round_ctrl
    import morse_round_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = 8,
    parameter int MAX_MISSES = 3,
    parameter int ROUND_W    = 4,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    morse_round_ctrl_if.slave  bus
);

    state_t              state_q;
    state_t              state_d;
    logic [ROUND_W-1:0]  round_q;
    logic [SCORE_W-1:0]  score_q;
    logic [SCORE_W-1:0]  misses_q;
    logic                miss_limit;
    logic                last_round;

    // Loss takes priority over finishing the last round.
    assign miss_limit = (misses_q == SCORE_W'(MAX_MISSES));
    assign last_round = (round_q == ROUND_W'(NUM_ROUNDS - 1));

    // State register; reset abandons any game in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = ST_WAIT;
            ST_WAIT:  state_d = (bus.answer_valid || bus.tmr_timeout) ? ST_JUDGE : ST_WAIT;
            ST_JUDGE: state_d = (miss_limit || last_round) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = bus.start ? ST_LOAD : ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Round index and score counters; an answer beats a same-cycle timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_q  <= '0;
            score_q  <= '0;
            misses_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        round_q  <= '0;
                        score_q  <= '0;
                        misses_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.answer_valid) begin
                        if (bus.answer_correct) score_q  <= score_q + 1'b1;
                        else                    misses_q <= misses_q + 1'b1;
                    end else if (bus.tmr_timeout) begin
                        misses_q <= misses_q + 1'b1;
                    end
                end
                ST_JUDGE: begin
                    if (!(miss_limit || last_round)) round_q <= round_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register and the registered counters.
    always_comb begin
        bus.tmr_en      = 1'b0;
        bus.tmr_restart = 1'b0;
        bus.playing     = 1'b0;
        bus.game_over   = 1'b0;
        bus.game_won    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                bus.tmr_restart = 1'b1;
                bus.playing     = 1'b1;
            end
            ST_WAIT: begin
                bus.tmr_en  = 1'b1;
                bus.playing = 1'b1;
            end
            ST_JUDGE: bus.playing = 1'b1;
            ST_DONE: begin
                bus.game_over = 1'b1;
                bus.game_won  = (misses_q < SCORE_W'(MAX_MISSES));
            end
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.round_idx = round_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for the round sequencer with 4 rounds and 2 allowed misses.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there.
// Backpressure: n/a.
module tb_morse_round_ctrl;

    localparam int NR = 4;
    localparam int MM = 2;
    localparam int RW = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    morse_round_ctrl_if #(.ROUND_W(RW), .SCORE_W(SW)) bus ();

    morse_round_ctrl #(
        .NUM_ROUNDS(NR),
        .MAX_MISSES(MM),
        .ROUND_W   (RW),
        .SCORE_W   (SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks state/counters and the flags implied by the expected state.
    task automatic chk_all(input string tag, input int st, input int ri, input int sc, input int mi);
        chk({tag, ".state"},       32'(bus.state),       32'(st));
        chk({tag, ".round_idx"},   32'(bus.round_idx),   32'(ri));
        chk({tag, ".score"},       32'(bus.score),       32'(sc));
        chk({tag, ".misses"},      32'(bus.misses),      32'(mi));
        chk({tag, ".tmr_en"},      32'(bus.tmr_en),      32'(st == 2));
        chk({tag, ".tmr_restart"}, 32'(bus.tmr_restart), 32'(st == 1));
        chk({tag, ".playing"},     32'(bus.playing),     32'(st >= 1 && st <= 3));
        chk({tag, ".game_over"},   32'(bus.game_over),   32'(st == 4));
        chk({tag, ".game_won"},    32'(bus.game_won),    32'(st == 4 && mi < MM));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b0;
        bus.start          = 1'b0;
        bus.answer_valid   = 1'b0;
        bus.answer_correct = 1'b0;
        bus.tmr_timeout    = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Answers and timeouts are ignored in IDLE.
        bus.answer_valid = 1'b1; bus.answer_correct = 1'b1; bus.tmr_timeout = 1'b1;
        tick();
        bus.answer_valid = 1'b0; bus.answer_correct = 1'b0; bus.tmr_timeout = 1'b0;
        chk_all("idle_ign", 0, 0, 0, 0);

        // Perfect game.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_all("pg_load0", 1, 0, 0, 0);
        for (int r = 0; r < NR; r++) begin
            if (r == 0) begin
                // Answer and timeout presented while in LOAD are dropped.
                bus.answer_valid = 1'b1; bus.tmr_timeout = 1'b1;
            end
            tick();
            bus.answer_valid = 1'b0; bus.tmr_timeout = 1'b0;
            chk_all($sformatf("pg_wait%0d", r), 2, r, r, 0);
            repeat (9) tick();
            if (r == 0) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                chk_all("pg_start_in_wait", 2, 0, 0, 0);
            end
            bus.answer_valid = 1'b1; bus.answer_correct = 1'b1;
            tick();
            bus.answer_valid = 1'b0; bus.answer_correct = 1'b0;
            chk_all($sformatf("pg_judge%0d", r), 3, r, r + 1, 0);
            if (r == 1) bus.answer_valid = 1'b1;
            tick();
            bus.answer_valid = 1'b0;
            if (r < NR - 1) chk_all($sformatf("pg_load%0d", r + 1), 1, r + 1, r + 1, 0);
            else            chk_all("pg_done", 4, NR - 1, NR, 0);
        end
        tick();
        chk_all("pg_done_hold", 4, NR - 1, NR, 0);

        // Collision game followed by a loss (wrong answer, timeout).
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_all("cg_load0", 1, 0, 0, 0);
        tick();
        chk_all("cg_wait0", 2, 0, 0, 0);
        bus.answer_valid = 1'b1; bus.answer_correct = 1'b1; bus.tmr_timeout = 1'b1;
        tick();
        bus.answer_valid = 1'b0; bus.answer_correct = 1'b0; bus.tmr_timeout = 1'b0;
        chk_all("cg_judge0", 3, 0, 1, 0);
        tick();
        chk_all("cg_load1", 1, 1, 1, 0);
        tick();
        chk_all("cg_wait1", 2, 1, 1, 0);
        bus.answer_valid = 1'b1; bus.answer_correct = 1'b0;
        tick();
        bus.answer_valid = 1'b0;
        chk_all("cg_judge1", 3, 1, 1, 1);
        tick();
        chk_all("cg_load2", 1, 2, 1, 1);
        tick();
        chk_all("cg_wait2", 2, 2, 1, 1);
        bus.tmr_timeout = 1'b1;
        tick();
        bus.tmr_timeout = 1'b0;
        chk_all("cg_judge2", 3, 2, 1, 2);
        tick();
        chk_all("cg_done", 4, 2, 1, 2);

        // Restart from DONE, then a timeout loss with timeout held as a level.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_all("to_load0", 1, 0, 0, 0);
        tick();
        chk_all("to_wait0", 2, 0, 0, 0);
        repeat (3) tick();
        bus.tmr_timeout = 1'b1;
        tick();
        chk_all("to_judge0", 3, 0, 0, 1);
        tick();
        chk_all("to_load1", 1, 1, 0, 1);
        tick();
        chk_all("to_wait1", 2, 1, 0, 1);
        tick();
        chk_all("to_judge1", 3, 1, 0, 2);
        bus.tmr_timeout = 1'b0;
        tick();
        chk_all("to_done", 4, 1, 0, 2);
        tick();
        chk_all("to_done_hold", 4, 1, 0, 2);

        // Asynchronous reset in the middle of WAIT.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.answer_valid = 1'b1; bus.answer_correct = 1'b1;
        tick();
        bus.answer_valid = 1'b0; bus.answer_correct = 1'b0;
        tick();
        tick();
        chk_all("mr_wait1", 2, 1, 1, 0);
        #2 rst = 1'b0;
        #1 chk_all("mr_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all("mr_idle", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_round_ctrl.md
Name: morse_round_ctrl

Overview:
Game-round sequencer for the Morse game. It owns the five-second answer timer: restarts it at the start of each round, enables it while the player answers, and stops it when the round is judged. It steps a round index, used as the Morse ROM address, and keeps score and miss counts. It declares win or loss. It sits between the top-level game control and the timer/ROM datapath.

Parameters:
NUM_ROUNDS, 8, rounds per game; must be at least 1.
MAX_MISSES, 3, misses (wrong answer or timeout) that end the game as a loss; must be at least 1.
ROUND_W, 4, width of round_idx; 2^ROUND_W must be at least NUM_ROUNDS.
SCORE_W, 4, width of score and misses counters; 2^SCORE_W must be greater than NUM_ROUNDS.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a game from IDLE or DONE
answer_valid  in  1  one-cycle pulse; player answer is present
answer_correct  in  1  qualifies answer_valid; 1 = correct
tmr_timeout  in  1  five-second timer expiry (level or pulse)
tmr_en  out  1  enable to the five-second timer
tmr_restart  out  1  one-cycle pulse; top level ORs it into the timer's reset
round_idx  out  ROUND_W  current round, 0-based; ROM address
score  out  SCORE_W  correct answers this game
misses  out  SCORE_W  wrong answers plus timeouts this game
playing  out  1  high in LOAD, WAIT and JUDGE
game_over  out  1  high in DONE
game_won  out  1  high in DONE when misses < MAX_MISSES
state  out  3  encoded FSM state, for debug and LEDs

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - round_idx, score and misses = 0.
  - tmr_en, tmr_restart, playing, game_over and game_won = 0.
- All other updates happen on the rising edge of clk. Every output is registered or decoded only from state.
- State encodings: IDLE=0, LOAD=1, WAIT=2, JUDGE=3, DONE=4. Encodings 5-7 return to IDLE on the next edge.
- IDLE:
  - On start, clear round_idx, score and misses, then go to LOAD.
  - Answers and timeouts are ignored.
- LOAD (exactly 1 cycle):
  - tmr_restart=1 and tmr_en=0.
  - round_idx is stable for the ROM.
  - Next state is WAIT. tmr_timeout is ignored here, since the timer is being restarted.
- WAIT:
  - tmr_en=1.
  - answer_valid=1: score increments if answer_correct=1, otherwise misses increments. Either way, go to JUDGE.
  - tmr_timeout=1 with no answer: misses increments, then go to JUDGE.
  - Simultaneous answer_valid and tmr_timeout: the answer wins and the timeout is discarded.
  - The score/misses update becomes visible in the JUDGE cycle.
- JUDGE (exactly 1 cycle), tmr_en=0:
  - If misses == MAX_MISSES, go to DONE (loss).
  - Else if round_idx == NUM_ROUNDS-1, go to DONE (win).
  - Else round_idx increments and the next state is LOAD.
- DONE:
  - game_over=1 and tmr_en=0. Counters hold their values for display.
  - On start, clear the counters, set round_idx=0 and go to LOAD.
- start is ignored in LOAD, WAIT and JUDGE.
- answer_valid is ignored outside WAIT.
- Latency: start to first tmr_restart is 1 cycle. start to tmr_en is 2 cycles. Answer to the next round's tmr_restart is 2 cycles (JUDGE, then LOAD).
- Counters never wrap: score ≤ NUM_ROUNDS and misses ≤ MAX_MISSES by construction.
- Reset mid-round drops tmr_en immediately; the game is abandoned.

Decomposition:
- Shared package: state encodings (ST_IDLE..ST_DONE) and the state width constant 3.
- No sub-module. A single FSM with its counters is natural; the timer stays external and instantiated at top level.

Test Plan:
Bench uses NUM_ROUNDS=4 and MAX_MISSES=2.
- Reset: assert rst=0 mid-WAIT -> state=0, tmr_en=0, round_idx=0, score=0, misses=0, all flags 0.
- Perfect game: start, then 4 correct answers each ~10 cycles into WAIT -> 4 tmr_restart pulses with round_idx 0,1,2,3; final score=4, misses=0, game_over=1, game_won=1.
- Timeout loss: start, then tmr_timeout in WAIT for rounds 0 and 1 -> misses=2, DONE after round_idx=1, game_won=0; tmr_en=0 throughout JUDGE and DONE.
- Collision: answer_valid=1 with answer_correct=1 and tmr_timeout=1 in the same WAIT cycle -> score=1, misses=0, exactly one JUDGE cycle.
- Ignored inputs: answer_valid during LOAD/JUDGE/IDLE, tmr_timeout during LOAD, start during WAIT -> no counter or state change.
- Restart from DONE: after a loss (score=1, misses=2), start -> counters clear to 0 and LOAD with round_idx=0 on the next edge.
